cordic_iter_core: RTL and testbench

CORDIC_ITER_CORE -- requirements
Module: cordic_iter_core

---
 rtl/cordic_pkg.sv | 45 ++++
 rtl/cordic_micro_rot.sv | 39 +++
 rtl/cordic_iter_core.sv | 140 ++++++++++++++
 tb/tb_cordic_iter_core.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC core: FSM encodings,
// arctangent table and the shift-add terms of the gain constant K.
package cordic_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_COMP = 2'd2;
    localparam state_t S_DONE = 2'd3;

    // Table resolution; other FRAC values are rescaled from it.
    localparam int ATAN_FRAC = 10;

    // K = 0.607253 ~ 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-12 + 2^-14
    localparam int K_SH_A = 1;
    localparam int K_SH_B = 3;
    localparam int K_SH_C = 6;
    localparam int K_SH_D = 9;
    localparam int K_SH_E = 12;
    localparam int K_SH_F = 14;

    function automatic int atan_fx(input int i, input int frac);
        int v;
        case (i)
            0:       v = 804;
            1:       v = 475;
            2:       v = 251;
            3:       v = 127;
            4:       v = 64;
            5:       v = 32;
            6:       v = 16;
            7:       v = 8;
            8:       v = 4;
            9:       v = 2;
            10:      v = 1;
            default: v = 0;
        endcase
        if (frac >= ATAN_FRAC)
            atan_fx = v <<< (frac - ATAN_FRAC);
        else
            atan_fx = v >>> (ATAN_FRAC - frac);
    endfunction

endpackage

// File: rtl/cordic_micro_rot.sv
// One CORDIC micro-rotation, purely combinational.
// d = 1 rotates by +atan(2^-i), d = 0 by -atan(2^-i).
module cordic_micro_rot
    import cordic_pkg::*;
#(
    parameter int W    = 15,
    parameter int IW   = 4,
    parameter int FRAC = 10
) (
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  y,
    input  logic signed [W-1:0]  z,
    input  logic        [IW-1:0] i,
    input  logic                 d,
    output logic signed [W-1:0]  x_nxt,
    output logic signed [W-1:0]  y_nxt,
    output logic signed [W-1:0]  z_nxt
);

    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;
    logic signed [W-1:0] at;

    always_comb begin
        xs = x >>> i;
        ys = y >>> i;
        at = W'(atan_fx(int'(i), FRAC));
        if (d) begin
            x_nxt = x - ys;
            y_nxt = y + xs;
            z_nxt = z - at;
        end else begin
            x_nxt = x + ys;
            y_nxt = y - xs;
            z_nxt = z + at;
        end
    end

endmodule

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC core, rotation or vectoring, valid/ready on both sides.
// Define CORDIC_GAIN_COMP_EN to add a COMP cycle scaling x/y by K.
module cordic_iter_core
    import cordic_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int FRAC  = 10,
    parameter int ITER  = 12
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] z_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             busy
);

    localparam int W  = WIDTH + 2;
    localparam int IW = (ITER > 2) ? $clog2(ITER) : 1;

    localparam logic signed [W-1:0] SMAX = W'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [W-1:0] SMIN = W'(-(1 << (WIDTH - 1)));

    state_t              state;
    logic                mode_r;
    logic [IW-1:0]       cnt;
    logic signed [W-1:0] x_r;
    logic signed [W-1:0] y_r;
    logic signed [W-1:0] z_r;
    logic signed [W-1:0] x_nxt;
    logic signed [W-1:0] y_nxt;
    logic signed [W-1:0] z_nxt;
    logic                d;

    function automatic logic [WIDTH-1:0] sat(input logic signed [W-1:0] v);
        if (v > SMAX)
            sat = SMAX[WIDTH-1:0];
        else if (v < SMIN)
            sat = SMIN[WIDTH-1:0];
        else
            sat = v[WIDTH-1:0];
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    function automatic logic signed [W-1:0] kmul(input logic signed [W-1:0] v);
        kmul = (v >>> K_SH_A) + (v >>> K_SH_B) - (v >>> K_SH_C)
             - (v >>> K_SH_D) - (v >>> K_SH_E) + (v >>> K_SH_F);
    endfunction
`endif

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign d        = mode_r ? y_r[W-1] : ~z_r[W-1];

    cordic_micro_rot #(
        .W    (W),
        .IW   (IW),
        .FRAC (FRAC)
    ) u_rot (
        .x     (x_r),
        .y     (y_r),
        .z     (z_r),
        .i     (cnt),
        .d     (d),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .z_nxt (z_nxt)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= S_IDLE;
            mode_r    <= 1'b0;
            cnt       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_r    <= W'($signed(x_in));
                        y_r    <= W'($signed(y_in));
                        z_r    <= W'($signed(z_in));
                        mode_r <= mode;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    x_r <= x_nxt;
                    y_r <= y_nxt;
                    z_r <= z_nxt;
                    if (cnt == IW'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state <= S_COMP;
`else
                        state <= S_DONE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_COMP: begin
                    x_r   <= kmul(x_r);
                    y_r   <= kmul(y_r);
                    state <= S_DONE;
                end
`endif
                S_DONE: begin
                    // First DONE cycle registers the clamped result.
                    if (!out_valid) begin
                        x_out     <= sat(x_r);
                        y_out     <= sat(y_r);
                        z_out     <= sat(z_r);
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter_core.sv
// Directed self-checking bench for cordic_iter_core.
// Expected values follow CORDIC_GAIN_COMP_EN when it is defined.
module tb_cordic_iter_core;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               mode = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [12:0] x_in = '0;
    logic signed [12:0] y_in = '0;
    logic signed [12:0] z_in = '0;
    logic               in_ready;
    logic               out_valid;
    logic               busy;
    logic signed [12:0] x_out;
    logic signed [12:0] y_out;
    logic signed [12:0] z_out;

    int total = 0;
    int bad = 0;

    typedef struct {
        string name;
        logic  m;
        int    x;
        int    y;
        int    z;
        int    ex;
        int    ey;
        int    ez;
        int    tol;
    } vec_t;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = 14;
`else
    localparam int LAT = 13;
`endif

    always #5 clk = ~clk;

    cordic_iter_core dut (
        .CLK       (clk),
        .RST_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .busy      (busy)
    );

    task automatic check(input string nm, input int act, input int exp, input int tol);
        total++;
        if (act < exp - tol || act > exp + tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    function automatic vec_t mkv(input string nm, input logic m,
                                 input int x, input int y, input int z,
                                 input int ex, input int ey, input int ez,
                                 input int tol);
        vec_t v;
        v.name = nm; v.m = m; v.x = x; v.y = y; v.z = z;
        v.ex = ex; v.ey = ey; v.ez = ez; v.tol = tol;
        return v;
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic m, input int xi, input int yi, input int zi,
                          output int lat);
        @(negedge clk);
        mode = m; x_in = 13'(xi); y_in = 13'(yi); z_in = 13'(zi);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
    endtask

    task automatic finish_op;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t vt[5];
        int   lat;
        int   cx, cy, cz;
        int   pulses;

`ifdef CORDIC_GAIN_COMP_EN
        vt[0] = mkv("rot_pi4", 1'b0, 1024, 0, 804, 724, 724, 0, 4);
        vt[1] = mkv("vec_45", 1'b1, 1024, 1024, 0, 1448, 0, 804, 4);
        vt[2] = mkv("rot_0", 1'b0, 1024, 0, 0, 1024, 0, 0, 4);
        vt[3] = mkv("sat_pos", 1'b0, 4095, 4095, 0, 4095, 4095, 0, 4);
        vt[4] = mkv("sat_neg", 1'b0, -4096, -4096, 0, -4096, -4096, 0, 4);
`else
        vt[0] = mkv("rot_pi4", 1'b0, 1024, 0, 804, 1192, 1192, 0, 4);
        vt[1] = mkv("vec_45", 1'b1, 1024, 1024, 0, 2385, 0, 804, 4);
        vt[2] = mkv("rot_0", 1'b0, 1024, 0, 0, 1686, 0, 0, 4);
        vt[3] = mkv("sat_pos", 1'b0, 4095, 4095, 0, 4095, 4095, 0, 0);
        vt[4] = mkv("sat_neg", 1'b0, -4096, -4096, 0, -4096, -4096, 0, 0);
`endif

        @(posedge clk); #2;
        check("rst_in_ready", int'(in_ready), 1, 0);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_busy", int'(busy), 0, 0);
        check("rst_x_out", int'(x_out), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            run_op(vt[k].m, vt[k].x, vt[k].y, vt[k].z, lat);
            check({vt[k].name, "_lat"}, lat, LAT, 0);
            check({vt[k].name, "_x"}, int'(x_out), vt[k].ex, vt[k].tol);
            check({vt[k].name, "_y"}, int'(y_out), vt[k].ey, vt[k].tol);
            check({vt[k].name, "_z"}, int'(z_out), vt[k].ez, 4);
            check({vt[k].name, "_busy"}, int'(busy), 1, 0);
            finish_op();
            check({vt[k].name, "_idle"}, int'(in_ready), 1, 0);
        end

        // Backpressure: results held while out_ready stays low.
        run_op(vt[0].m, vt[0].x, vt[0].y, vt[0].z, lat);
        cx = int'(x_out); cy = int'(y_out); cz = int'(z_out);
        check("bp_x", cx, vt[0].ex, 4);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_valid", int'(out_valid), 1, 0);
            check("bp_in_ready", int'(in_ready), 0, 0);
            check("bp_x_hold", int'(x_out), cx, 0);
            check("bp_y_hold", int'(y_out), cy, 0);
            check("bp_z_hold", int'(z_out), cz, 0);
        end
        finish_op();
        check("bp_release_valid", int'(out_valid), 0, 0);
        check("bp_release_busy", int'(busy), 0, 0);
        check("bp_release_ready", int'(in_ready), 1, 0);

        // in_valid held through RUN with other operands.
        @(negedge clk);
        mode = vt[0].m; x_in = 13'(vt[0].x); y_in = 13'(vt[0].y); z_in = 13'(vt[0].z);
        in_valid = 1'b1;
        @(posedge clk); #1;
        mode = 1'b1; x_in = -13'sd2000; y_in = 13'sd500; z_in = -13'sd300;
        @(posedge clk); #1;
        check("hold_in_ready", int'(in_ready), 0, 0);
        wait_valid(lat);
        in_valid = 1'b0;
        check("hold_lat", lat + 1, LAT, 0);
        check("hold_x", int'(x_out), vt[0].ex, 4);
        check("hold_y", int'(y_out), vt[0].ey, 4);
        check("hold_z", int'(z_out), vt[0].ez, 4);
        finish_op();
        check("hold_idle", int'(in_ready), 1, 0);

        // Reset in the middle of RUN.
        @(negedge clk);
        mode = vt[2].m; x_in = 13'(vt[2].x); y_in = 13'(vt[2].y); z_in = 13'(vt[2].z);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_x_out", int'(x_out), 0, 0);
        check("mrst_y_out", int'(y_out), 0, 0);
        check("mrst_valid", int'(out_valid), 0, 0);
        check("mrst_busy", int'(busy), 0, 0);
        check("mrst_in_ready", int'(in_ready), 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid || busy) pulses++;
        end
        check("mrst_no_pulse", pulses, 0, 0);
        run_op(vt[0].m, vt[0].x, vt[0].y, vt[0].z, lat);
        check("mrst_lat", lat, LAT, 0);
        check("mrst_x", int'(x_out), vt[0].ex, 4);
        check("mrst_y", int'(y_out), vt[0].ey, 4);
        finish_op();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
